// File: rtl/multi_sonic_ctl_pkg.sv
// Shared types and command/result field layout for the multi-channel sonic controller.
package msc_pkg;
  localparam int CNT_W       = 27;
  localparam int CMD_MASK_W  = 16;
  localparam int CMD_REP_BIT = 16;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_TRIG, S_HOLDOFF, S_WAIT_RISE, S_MEASURE, S_STORE, S_GAP
  } state_t;

  typedef struct packed {
    logic [3:0]       ch;
    logic             timeout;
    logic [CNT_W-1:0] width;
  } result_t;

  // Lowest set bit of mask at or above 'from'; returns 16 when there is none.
  function automatic logic [4:0] next_ch(input logic [15:0] mask, input logic [4:0] from);
    next_ch = 5'd16;
    for (int i = 15; i >= 0; i--)
      if (mask[i] && (5'(i) >= from)) next_ch = 5'(i);
  endfunction
endpackage

// File: rtl/multi_sonic_ctl_if.sv
// Host-side FIFO bus: command write port and result read port.
interface multi_sonic_ctl_if;
  logic [31:0] din_32;
  logic        wr_en_32;
  logic        full_32;
  logic [31:0] dout_32;
  logic        rd_en_32;
  logic        empty_32;

  modport master (output din_32, wr_en_32, rd_en_32, input full_32, dout_32, empty_32);
  modport slave  (input din_32, wr_en_32, rd_en_32, output full_32, dout_32, empty_32);
endinterface

// File: rtl/multi_sonic_ctl_sync_fifo.sv
// Single-clock FIFO with registered read data and registered full/empty flags.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_wr_en,
  output logic             o_full,
  output logic [WIDTH-1:0] o_dout,
  input  logic             i_rd_en,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [AW:0]      r_cnt, w_cnt_nxt;
  logic             w_push, w_pop;

  assign w_push    = i_wr_en & ~o_full;
  assign w_pop     = i_rd_en & ~o_empty;
  assign w_cnt_nxt = r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);

  always_ff @(posedge i_clk)
    if (w_push) r_mem[r_wptr] <= i_din;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_cnt   <= '0;
      o_full  <= 1'b0;
      o_empty <= 1'b1;
      o_dout  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop) begin
        o_dout <= r_mem[r_rptr];
        r_rptr <= r_rptr + AW'(1);
      end
      r_cnt   <= w_cnt_nxt;
      o_full  <= (w_cnt_nxt == (AW+1)'(DEPTH));
      o_empty <= (w_cnt_nxt == '0);
    end
  end
endmodule

// File: rtl/multi_sonic_ctl.sv
// Time-shared ping-sensor engine: scans a channel mask, triggers each shared pin,
// times the echo and queues {ch, timeout, width} results without loss.
module multi_sonic_ctl
  import msc_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int FIFO_DEPTH  = 512,
  parameter int TRIG_CYC    = 1000,
  parameter int HOLDOFF_CYC = 75000,
  parameter int TIMEOUT_CYC = 2000000,
  parameter int GAP_CYC     = 20000
) (
  input  logic              CLK,
  input  logic              RST,
  multi_sonic_ctl_if.slave  bus,
  inout  wire  [NUM_CH-1:0] SIG_OUT,
  output logic              busy
);
  localparam logic [15:0] CH_MASK = 16'((32'd1 << NUM_CH) - 32'd1);

  state_t            r_state, w_nxt;
  logic [15:0]       r_mask;
  logic              r_rep;
  logic [3:0]        r_ch;
  logic [CNT_W-1:0]  r_cnt;
  result_t           r_res;
  logic [NUM_CH-1:0] r_s1, r_s2, r_s3;

  logic [31:0] w_cmd;
  logic        w_cmd_empty, w_cmd_pop, w_res_full, w_res_push;
  logic [15:0] w_cmd_mask, w_s2, w_s3;
  logic [4:0]  w_fetch_first, w_first, w_after;
  logic        w_echo, w_rise, w_unused;

  sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_cmd_fifo (
    .i_clk(CLK), .i_rst(RST),
    .i_din(bus.din_32), .i_wr_en(bus.wr_en_32), .o_full(bus.full_32),
    .o_dout(w_cmd), .i_rd_en(w_cmd_pop), .o_empty(w_cmd_empty)
  );

  sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_res_fifo (
    .i_clk(CLK), .i_rst(RST),
    .i_din(r_res), .i_wr_en(w_res_push), .o_full(w_res_full),
    .o_dout(bus.dout_32), .i_rd_en(bus.rd_en_32), .o_empty(bus.empty_32)
  );

  assign w_cmd_mask    = w_cmd[CMD_MASK_W-1:0] & CH_MASK;
  assign w_fetch_first = next_ch(w_cmd_mask, 5'd0);
  assign w_first       = next_ch(r_mask, 5'd0);
  assign w_after       = next_ch(r_mask, {1'b0, r_ch} + 5'd1);
  assign w_s2          = 16'(r_s2);
  assign w_s3          = 16'(r_s3);
  assign w_echo        = w_s2[r_ch];
  assign w_rise        = w_s2[r_ch] & ~w_s3[r_ch];
  assign busy          = (r_state != S_IDLE);
  assign w_unused      = ^{w_cmd[31:CMD_REP_BIT+1], w_first[4]};

  for (genvar g = 0; g < NUM_CH; g++) begin : g_pin
    assign SIG_OUT[g] = (r_state == S_TRIG && r_ch == 4'(g)) ? 1'b1 : 1'bz;
  end

  // The command pop is issued on the transition into FETCH so the word is
  // already on the FIFO output while FETCH latches it.
  always_comb begin
    w_nxt      = r_state;
    w_cmd_pop  = 1'b0;
    w_res_push = 1'b0;
    case (r_state)
      S_IDLE:      if (!w_cmd_empty) begin w_nxt = S_FETCH; w_cmd_pop = 1'b1; end
      S_FETCH:     w_nxt = w_fetch_first[4] ? S_IDLE : S_TRIG;
      S_TRIG:      if (r_cnt == CNT_W'(TRIG_CYC - 1)) w_nxt = S_HOLDOFF;
      S_HOLDOFF:   if (r_cnt == CNT_W'(HOLDOFF_CYC - 1)) w_nxt = S_WAIT_RISE;
      S_WAIT_RISE: if (w_rise) w_nxt = S_MEASURE;
                   else if (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) w_nxt = S_STORE;
      S_MEASURE:   if (!w_echo || r_cnt == CNT_W'(TIMEOUT_CYC)) w_nxt = S_STORE;
      S_STORE:     if (!w_res_full) begin w_res_push = 1'b1; w_nxt = S_GAP; end
      S_GAP:
        if (r_cnt == CNT_W'(GAP_CYC - 1)) begin
          if (!w_after[4])     w_nxt = S_TRIG;
          else if (!r_rep)     w_nxt = S_IDLE;
          else if (w_cmd_empty) w_nxt = S_TRIG;
          else begin w_nxt = S_FETCH; w_cmd_pop = 1'b1; end
        end
      default:     w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_mask  <= '0;
      r_rep   <= 1'b0;
      r_ch    <= '0;
      r_cnt   <= '0;
      r_res   <= '0;
      r_s1    <= '0;
      r_s2    <= '0;
      r_s3    <= '0;
    end else begin
      r_state <= w_nxt;
      r_s1    <= SIG_OUT;
      r_s2    <= r_s1;
      r_s3    <= r_s2;
      // One shared counter: phase timer everywhere, echo width in MEASURE.
      if (w_nxt != r_state) r_cnt <= (w_nxt == S_MEASURE) ? CNT_W'(1) : '0;
      else                  r_cnt <= r_cnt + CNT_W'(1);
      if (r_state == S_FETCH) begin
        r_mask <= w_cmd_mask;
        r_rep  <= w_cmd[CMD_REP_BIT];
        r_ch   <= w_fetch_first[3:0];
      end
      if (r_state == S_GAP && w_nxt == S_TRIG)
        r_ch <= w_after[4] ? w_first[3:0] : w_after[3:0];
      if (r_state == S_WAIT_RISE && w_nxt == S_STORE)
        r_res <= '{ch: r_ch, timeout: 1'b1, width: CNT_W'(TIMEOUT_CYC)};
      if (r_state == S_MEASURE && w_nxt == S_STORE)
        r_res <= w_echo ? '{ch: r_ch, timeout: 1'b1, width: CNT_W'(TIMEOUT_CYC)}
                        : '{ch: r_ch, timeout: 1'b0, width: r_cnt};
    end
  end
endmodule
